demux_bit_sequencer: RTL and testbench

Upstream feeder for demux_1to8. Accepts one 8-bit byte over a valid/ready handshake, then walks the select bus through all eight channels and presents the matching data bit on d at each step, holding each step for a programmable number of cycles. Its d/s outputs connect directly to demux_1to8 d/s. Its out_en/done strobes tell the consumer when the demux outputs are meaningful and when a byte has been fully distributed.

---
 rtl/demux_bit_sequencer.sv | 130 +++++++++++++
 tb/tb_demux_bit_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/demux_bit_sequencer.sv
// Serialises one accepted byte onto demux_1to8 d/s, one channel per step, each held HOLD_CYCLES.
// Latency: step 0 appears right after the accept edge; done is a 1-cycle pulse after step 7; in_ready is low only in SEND.
module demux_bit_sequencer #(
  parameter int HOLD_CYCLES = 1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       d,
  output logic [2:0] s,
  output logic       out_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0] FIRST_IDX = MSB_FIRST ? 3'd7 : 3'd0;

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [2:0] step_q, step_d;
  logic       last_q, last_d;
  logic [7:0] byte_q, byte_d;
  logic [2:0] sel_q, sel_d;
  logic       in_ready_q, in_ready_d;
  logic       d_q, d_d;
  logic       out_en_q, out_en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       accept;

  // in_ready is a register, so accept never loops back into in_ready combinationally.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    step_d  = step_q;
    last_d  = last_q;
    byte_d  = byte_q;
    sel_d   = sel_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = SEND;
          byte_d  = in_data;
          sel_d   = FIRST_IDX;
          hold_d  = 4'd0;
          step_d  = 3'd0;
          last_d  = 1'b0;
        end else begin
          state_d = IDLE;
          sel_d   = 3'd0;
        end
      end
      SEND: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = 4'd0;
          if (last_q) begin
            state_d = DONE;
            sel_d   = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
            last_d = (step_q == 3'd6);
            sel_d  = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 3'd0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d = (state_d != SEND);
    out_en_d   = (state_d == SEND);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    d_d        = (state_d == SEND) ? byte_d[sel_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= 4'd0;
      step_q     <= 3'd0;
      last_q     <= 1'b0;
      byte_q     <= 8'd0;
      sel_q      <= 3'd0;
      in_ready_q <= 1'b1;
      d_q        <= 1'b0;
      out_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      step_q     <= step_d;
      last_q     <= last_d;
      byte_q     <= byte_d;
      sel_q      <= sel_d;
      in_ready_q <= in_ready_d;
      d_q        <= d_d;
      out_en_q   <= out_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign d        = d_q;
  assign s        = sel_q;
  assign out_en   = out_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// Directed bench: instance 0 is HOLD=1/LSB-first, instance 1 is HOLD=3/MSB-first.
module tb_demux_bit_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1;
  logic [7:0] dat0, dat1;
  logic       in_ready0, d0, out_en0, busy0, done0;
  logic       in_ready1, d1, out_en1, busy1, done1;
  logic [2:0] s0, s1;
  logic [7:0] o0, o1;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         acc_a, acc_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  demux_bit_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_data(dat0), .in_ready(in_ready0),
    .d(d0), .s(s0), .out_en(out_en0), .busy(busy0), .done(done0)
  );

  demux_bit_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(dat1), .in_ready(in_ready1),
    .d(d1), .s(s1), .out_en(out_en1), .busy(busy1), .done(done1)
  );

  // Packed view: {in_ready, d, s[2:0], out_en, busy, done}
  assign o0 = {in_ready0, d0, s0, out_en0, busy0, done0};
  assign o1 = {in_ready1, d1, s1, out_en1, busy1, done1};

  localparam logic [7:0] IDLE_V = 8'h80;
  localparam logic [7:0] DONE_V = 8'h83;

  function automatic logic [7:0] pk(input logic r, input logic dd, input logic [2:0] ss,
                                    input logic e, input logic b, input logic dn);
    return {r, dd, ss, e, b, dn};
  endfunction

  function automatic logic [7:0] obs(input int w);
    return (w == 0) ? o0 : o1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [7:0] x);
    if (w == 0) begin
      v0 = v; dat0 = x;
    end else begin
      v1 = v; dat1 = x;
    end
  endtask

  // Entered at the negedge right after the accept edge; leaves at the done-cycle negedge.
  task automatic frame_check(input string tag, input int w, input logic [7:0] b,
                             input int hold, input bit msb, input bit noise);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] idx;
      idx = msb ? 3'(7 - k) : 3'(k);
      for (int h = 0; h < hold; h++) begin
        chk($sformatf("%s step%0d.%0d", tag, k, h), {24'd0, obs(w)},
            {24'd0, pk(1'b0, b[idx], idx, 1'b1, 1'b1, 1'b0)});
        if (noise) drive(w, 1'($urandom & 1), 8'($urandom));
        @(negedge clk);
      end
    end
    if (noise) drive(w, 1'b0, 8'h00);
    chk({tag, " done"}, {24'd0, obs(w)}, {24'd0, DONE_V});
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);

    // Reset, then reset again while idle
    repeat (2) @(negedge clk);
    chk("rst0 u0", {24'd0, o0}, {24'd0, IDLE_V});
    chk("rst0 u1", {24'd0, o1}, {24'd0, IDLE_V});
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle u0", {24'd0, o0}, {24'd0, IDLE_V});
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst1 u0", {24'd0, o0}, {24'd0, IDLE_V});
    chk("rst1 u1", {24'd0, o1}, {24'd0, IDLE_V});
    rst = 1'b0;

    // Single byte, HOLD=1, LSB first
    @(negedge clk);
    drive(0, 1'b1, 8'b1010_0110);
    chk("t2 ready", {24'd0, o0}, {24'd0, IDLE_V});
    @(negedge clk);
    drive(0, 1'b0, 8'h5F);
    frame_check("t2", 0, 8'b1010_0110, 1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2 idle", {24'd0, o0}, {24'd0, IDLE_V});

    // HOLD=3, MSB first
    drive(1, 1'b1, 8'hC3);
    @(negedge clk);
    drive(1, 1'b0, 8'h00);
    acc_a = cyc;
    frame_check("t3", 1, 8'hC3, 3, 1'b1, 1'b0);
    chk("t3 done cycle", 32'(cyc - acc_a + 1), 32'd25);
    @(negedge clk);
    chk("t3 idle", {24'd0, o1}, {24'd0, IDLE_V});

    // Back-to-back with in_valid held high
    drive(0, 1'b1, 8'hFF);
    @(negedge clk);
    acc_a = cyc;
    drive(0, 1'b1, 8'h00);
    frame_check("t4a", 0, 8'hFF, 1, 1'b0, 1'b0);
    @(negedge clk);
    acc_b = cyc;
    drive(0, 1'b0, 8'h00);
    chk("t4 accept gap", 32'(acc_b - acc_a), 32'd9);
    frame_check("t4b", 0, 8'h00, 1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4 idle", {24'd0, o0}, {24'd0, IDLE_V});

    // Reset in the middle of a frame
    drive(0, 1'b1, 8'h5A);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] b5;
      b5 = 8'h5A;
      chk($sformatf("t5 step%0d", k), {24'd0, o0},
          {24'd0, pk(1'b0, b5[k], 3'(k), 1'b1, 1'b1, 1'b0)});
      if (k < 4) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 rst", {24'd0, o0}, {24'd0, IDLE_V});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t5 quiet%0d", k), {24'd0, o0}, {24'd0, IDLE_V});
    end
    drive(0, 1'b1, 8'h3C);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    frame_check("t5 next", 0, 8'h3C, 1, 1'b0, 1'b0);
    @(negedge clk);

    // Input noise while busy must not disturb the latched byte
    drive(1, 1'b1, 8'h96);
    @(negedge clk);
    frame_check("t6 u1", 1, 8'h96, 3, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6 u1 idle", {24'd0, o1}, {24'd0, IDLE_V});
    drive(0, 1'b1, 8'h69);
    @(negedge clk);
    frame_check("t6 u0", 0, 8'h69, 1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6 u0 idle", {24'd0, o0}, {24'd0, IDLE_V});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
